// File: rtl/clkdiv_pkg.sv
//------------------------------------------------------------------------------
// Module   : clkdiv_pkg
// Brief    : Shared defaults and select-FSM state encoding for the clock
//            divider/selector sequencer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clkdiv_pkg;

  localparam int CLKDIV_NUM_CH         = 4;
  localparam int CLKDIV_FACTOR_W       = 6;
  localparam int CLKDIV_SEL_W          = 2;
  localparam int CLKDIV_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_CUR = 2'd1,
    S_WAIT_TGT = 2'd2,
    S_RELEASE  = 2'd3
  } sel_state_t;

endpackage : clkdiv_pkg

`default_nettype wire

// File: rtl/clkdiv_factor_shadow.sv
//------------------------------------------------------------------------------
// Module   : clkdiv_factor_shadow
// Brief    : One channel's shadow factor and pending bit; the shadow is copied
//            to the live factor on the next toggle of that channel's clock.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clkdiv_factor_shadow
  import clkdiv_pkg::*;
#(
  parameter int FACTOR_W = CLKDIV_FACTOR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [FACTOR_W-1:0] wr_factor,
  input  logic                tog,
  output logic                pending,
  output logic [FACTOR_W-1:0] factor
);

  logic [FACTOR_W-1:0] r_shadow;
  logic [FACTOR_W-1:0] r_factor;
  logic                r_pending;

  // wr_en is only raised while not pending, so a same-cycle toggle never commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_factor  <= '0;
      r_pending <= 1'b0;
    end else if (wr_en) begin
      r_shadow  <= wr_factor;
      r_pending <= 1'b1;
    end else if (tog && r_pending) begin
      r_factor  <= r_shadow;
      r_pending <= 1'b0;
    end
  end

  assign pending = r_pending;
  assign factor  = r_factor;

endmodule : clkdiv_factor_shadow

`default_nettype wire

// File: rtl/clkdiv_select_sequencer.sv
//------------------------------------------------------------------------------
// Module   : clkdiv_select_sequencer
// Brief    : Commits per-channel divide factors on divided-clock toggles and
//            switches the output select glitch-free (park low, switch, release).
//            Optional phase timeout enabled by CLKDIV_SEL_TIMEOUT_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clkdiv_select_sequencer
  import clkdiv_pkg::*;
#(
  parameter int NUM_CH         = CLKDIV_NUM_CH,
  parameter int FACTOR_W       = CLKDIV_FACTOR_W,
  parameter int SEL_W          = CLKDIV_SEL_W,
  parameter int TIMEOUT_CYCLES = CLKDIV_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [SEL_W-1:0]           cfg_ch,
  input  logic [FACTOR_W-1:0]        cfg_factor,
  input  logic                       sel_valid,
  output logic                       sel_ready,
  input  logic [SEL_W-1:0]           sel_ch,
  input  logic [NUM_CH-1:0]          div_clk_in,
  output logic [NUM_CH*FACTOR_W-1:0] div_factor,
  output logic [SEL_W-1:0]           clock_select,
  output logic                       out_hold,
  output logic                       busy,
  output logic                       timeout
);

  logic [NUM_CH-1:0] r_prev_div;
  logic [NUM_CH-1:0] w_tog;
  logic [NUM_CH-1:0] w_pending;
  sel_state_t        r_state;
  logic [SEL_W-1:0]  r_tgt;
  logic [SEL_W-1:0]  r_clock_select;
  logic              r_out_hold;

  always_ff @(posedge clk) begin
    if (rst) r_prev_div <= '0;
    else     r_prev_div <= div_clk_in;
  end

  assign w_tog     = div_clk_in ^ r_prev_div;
  assign cfg_ready = ~w_pending[cfg_ch];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_wr_en;
    assign w_wr_en = cfg_valid && cfg_ready && (cfg_ch == SEL_W'(i));

    clkdiv_factor_shadow #(.FACTOR_W(FACTOR_W)) u_shadow (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (w_wr_en),
      .wr_factor (cfg_factor),
      .tog       (w_tog[i]),
      .pending   (w_pending[i]),
      .factor    (div_factor[i*FACTOR_W +: FACTOR_W])
    );
  end

`ifdef CLKDIV_SEL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  assign timeout = r_timeout;
`else
  // TIMEOUT_CYCLES only shapes the build with the timeout counter present.
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_tgt          <= '0;
      r_clock_select <= '0;
      r_out_hold     <= 1'b0;
`ifdef CLKDIV_SEL_TIMEOUT_EN
      r_cnt          <= '0;
      r_timeout      <= 1'b0;
`endif
    end else begin
`ifdef CLKDIV_SEL_TIMEOUT_EN
      r_timeout <= 1'b0;
      if (r_cnt != C_CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
`endif
      case (r_state)
        S_IDLE: begin
          if (sel_valid && (sel_ch != r_clock_select)) begin
            r_tgt   <= sel_ch;
            r_state <= S_WAIT_CUR;
`ifdef CLKDIV_SEL_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_WAIT_CUR: begin
          if (!div_clk_in[r_clock_select]) begin
            r_out_hold <= 1'b1;
            r_state    <= S_WAIT_TGT;
`ifdef CLKDIV_SEL_TIMEOUT_EN
            r_cnt      <= '0;
          end else if (r_cnt == C_CNT_MAX) begin
            r_out_hold     <= 1'b1;
            r_clock_select <= r_tgt;
            r_state        <= S_RELEASE;
            r_timeout      <= 1'b1;
            r_cnt          <= '0;
`endif
          end
        end
        S_WAIT_TGT: begin
          if (!div_clk_in[r_tgt]) begin
            r_clock_select <= r_tgt;
            r_state        <= S_RELEASE;
`ifdef CLKDIV_SEL_TIMEOUT_EN
            r_cnt          <= '0;
          end else if (r_cnt == C_CNT_MAX) begin
            r_out_hold     <= 1'b1;
            r_clock_select <= r_tgt;
            r_state        <= S_RELEASE;
            r_timeout      <= 1'b1;
            r_cnt          <= '0;
`endif
          end
        end
        default: begin
          r_out_hold <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign clock_select = r_clock_select;
  assign out_hold     = r_out_hold;
  assign sel_ready    = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE) || (|w_pending);

endmodule : clkdiv_select_sequencer

`default_nettype wire

// File: tb/tb_clkdiv_select_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_clkdiv_select_sequencer
// Brief    : Directed vector table for the factor path plus hand-written select
//            sequences, reset-abort and phase-timeout scenarios.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_clkdiv_select_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_ch;
  logic [5:0]  cfg_factor;
  logic        sel_valid;
  logic        sel_ready;
  logic [1:0]  sel_ch;
  logic [3:0]  div_clk_in;
  logic [23:0] div_factor;
  logic [1:0]  clock_select;
  logic        out_hold;
  logic        busy;
  logic        timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  clkdiv_select_sequencer #(
    .NUM_CH(4), .FACTOR_W(6), .SEL_W(2), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_factor(cfg_factor),
    .sel_valid(sel_valid), .sel_ready(sel_ready), .sel_ch(sel_ch),
    .div_clk_in(div_clk_in), .div_factor(div_factor), .clock_select(clock_select),
    .out_hold(out_hold), .busy(busy), .timeout(timeout)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  ch;
    logic [5:0]  factor;
    logic [3:0]  div;
    logic        exp_ready;
    logic [23:0] exp_factor;
    logic        exp_busy;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hit;
    // inputs (valid, ch, factor, div) -> ready before edge, factors and busy after edge
    vecs[0]  = '{1'b1, 2'd1, 6'd10, 4'b0000, 1'b1, 24'd0,        1'b1};
    vecs[1]  = '{1'b0, 2'd1, 6'd0,  4'b0000, 1'b0, 24'd0,        1'b1};
    vecs[2]  = '{1'b0, 2'd1, 6'd0,  4'b0000, 1'b0, 24'd0,        1'b1};
    vecs[3]  = '{1'b0, 2'd1, 6'd0,  4'b0010, 1'b0, 24'd640,      1'b0};
    vecs[4]  = '{1'b0, 2'd1, 6'd0,  4'b0010, 1'b1, 24'd640,      1'b0};
    vecs[5]  = '{1'b1, 2'd2, 6'd5,  4'b0010, 1'b1, 24'd640,      1'b1};
    vecs[6]  = '{1'b1, 2'd2, 6'd33, 4'b0010, 1'b0, 24'd640,      1'b1};
    vecs[7]  = '{1'b1, 2'd2, 6'd33, 4'b0110, 1'b0, 24'd21120,    1'b0};
    vecs[8]  = '{1'b1, 2'd2, 6'd33, 4'b0110, 1'b1, 24'd21120,    1'b1};
    vecs[9]  = '{1'b0, 2'd2, 6'd0,  4'b0010, 1'b0, 24'd135808,   1'b0};
    vecs[10] = '{1'b1, 2'd0, 6'd7,  4'b0011, 1'b1, 24'd135808,   1'b1};
    vecs[11] = '{1'b0, 2'd0, 6'd0,  4'b0011, 1'b0, 24'd135808,   1'b1};
    vecs[12] = '{1'b0, 2'd0, 6'd0,  4'b0010, 1'b0, 24'd135815,   1'b0};
    vecs[13] = '{1'b1, 2'd3, 6'd63, 4'b0010, 1'b1, 24'd135815,   1'b1};
    vecs[14] = '{1'b1, 2'd1, 6'd1,  4'b0010, 1'b1, 24'd135815,   1'b1};
    vecs[15] = '{1'b1, 2'd0, 6'd2,  4'b0010, 1'b1, 24'd135815,   1'b1};
    vecs[16] = '{1'b1, 2'd2, 6'd3,  4'b0010, 1'b1, 24'd135815,   1'b1};
    vecs[17] = '{1'b0, 2'd0, 6'd0,  4'b1101, 1'b0, 24'd16527426, 1'b0};
    vecs[18] = '{1'b0, 2'd0, 6'd0,  4'b1101, 1'b1, 24'd16527426, 1'b0};

    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_factor = '0;
    sel_valid = 1'b0; sel_ch = '0; div_clk_in = '0;
    step(); step(); step();
    rst = 1'b0;
    chk("reset_factor", {8'd0, div_factor}, 32'd0);
    chk("reset_select", {30'd0, clock_select}, 32'd0);
    chk("reset_hold", {31'd0, out_hold}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sel_ready", {31'd0, sel_ready}, 32'd1);

    for (int i = 0; i < 19; i++) begin
      cfg_valid = vecs[i].valid; cfg_ch = vecs[i].ch;
      cfg_factor = vecs[i].factor; div_clk_in = vecs[i].div;
      #1;
      chk($sformatf("vec%0d_cfg_ready", i), {31'd0, cfg_ready}, {31'd0, vecs[i].exp_ready});
      step();
      chk($sformatf("vec%0d_div_factor", i), {8'd0, div_factor}, {8'd0, vecs[i].exp_factor});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
    end
    cfg_valid = 1'b0;

    // same-channel select is a one-cycle no-op
    div_clk_in = 4'b0000; sel_valid = 1'b1; sel_ch = 2'd0;
    #1;
    chk("same_sel_ready", {31'd0, sel_ready}, 32'd1);
    step();
    sel_valid = 1'b0;
    chk("same_sel_idle", {31'd0, sel_ready}, 32'd1);
    chk("same_sel_hold", {31'd0, out_hold}, 32'd0);
    chk("same_sel_busy", {31'd0, busy}, 32'd0);

    // 0 -> 3 with both channels initially high
    div_clk_in = 4'b1001; sel_valid = 1'b1; sel_ch = 2'd3;
    step();
    sel_valid = 1'b0;
    chk("sw03_accept_ready", {31'd0, sel_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("sw03_wait_cur_hold%0d", i), {31'd0, out_hold}, 32'd0);
    end
    div_clk_in = 4'b1000;
    step();
    chk("sw03_hold_rise", {31'd0, out_hold}, 32'd1);
    chk("sw03_sel_still0", {30'd0, clock_select}, 32'd0);
    div_clk_in = 4'b1001;
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("sw03_wait_tgt_hold%0d", i), {31'd0, out_hold}, 32'd1);
      chk($sformatf("sw03_wait_tgt_sel%0d", i), {30'd0, clock_select}, 32'd0);
    end
    div_clk_in = 4'b0000;
    step();
    chk("sw03_sel3", {30'd0, clock_select}, 32'd3);
    chk("sw03_hold_kept", {31'd0, out_hold}, 32'd1);
    step();
    chk("sw03_release", {31'd0, out_hold}, 32'd0);
    chk("sw03_idle", {31'd0, sel_ready}, 32'd1);

    // best case 3 -> 1, all clocks low
    sel_valid = 1'b1; sel_ch = 2'd1;
    step();
    sel_valid = 1'b0;
    step();
    chk("sw31_hold", {31'd0, out_hold}, 32'd1);
    step();
    chk("sw31_sel", {30'd0, clock_select}, 32'd1);
    step();
    chk("sw31_release", {31'd0, out_hold}, 32'd0);
    chk("sw31_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of a switch with a write pending
    div_clk_in = 4'b0100; sel_valid = 1'b1; sel_ch = 2'd2;
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_factor = 6'd9;
    step();
    sel_valid = 1'b0; cfg_valid = 1'b0;
    step();
    chk("midsw_hold", {31'd0, out_hold}, 32'd1);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("midsw_rst_factor", {8'd0, div_factor}, 32'd0);
    chk("midsw_rst_select", {30'd0, clock_select}, 32'd0);
    chk("midsw_rst_hold", {31'd0, out_hold}, 32'd0);
    chk("midsw_rst_busy", {31'd0, busy}, 32'd0);
    cfg_ch = 2'd3;
    #1;
    chk("midsw_rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);

    // target clock stuck high: 0 -> 2
    div_clk_in = 4'b0100; sel_valid = 1'b1; sel_ch = 2'd2;
    step();
    sel_valid = 1'b0;
    step();
    chk("stuck_hold", {31'd0, out_hold}, 32'd1);
    chk("stuck_no_pulse", {31'd0, timeout}, 32'd0);
`ifdef CLKDIV_SEL_TIMEOUT_EN
    hit = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (timeout && hit == 0) begin
        hit = i;
        break;
      end
    end
    chk("to_cycle", hit, 32'd9);
    chk("to_forced_sel", {30'd0, clock_select}, 32'd2);
    chk("to_forced_hold", {31'd0, out_hold}, 32'd1);
    step();
    chk("to_pulse_end", {31'd0, timeout}, 32'd0);
    chk("to_release", {31'd0, out_hold}, 32'd0);
`else
    hit = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (timeout) hit++;
    end
    chk("stuck_busy", {31'd0, busy}, 32'd1);
    chk("stuck_timeout_never", hit, 32'd0);
    chk("stuck_sel", {30'd0, clock_select}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_clkdiv_select_sequencer

`default_nettype wire
